// File: rtl/imm_pkg.sv
// imm_pkg: format encodings, immediate range limits and stage types shared by imm_encoder and imm_pack
package imm_pkg;
   typedef enum logic [2:0] {FMT_I = 3'd0, FMT_S = 3'd1, FMT_B = 3'd2, FMT_U = 3'd3, FMT_J = 3'd4} fmt_e;
   localparam int IS_MIN = -2048;
   localparam int IS_MAX = 2047;
   localparam int B_MIN  = -4096;
   localparam int B_MAX  = 4094;
   localparam int J_MIN  = -1048576;
   localparam int J_MAX  = 1048574;
   typedef struct packed {
      logic [2:0]  fmt;
      logic [31:0] base;
      logic [31:0] off;
   } s1_t;
   function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
      return ($signed(v) >= lo) && ($signed(v) <= hi);
   endfunction
endpackage

// File: rtl/imm_pack.sv
// imm_pack: combinational immediate packing and range/alignment check
//   fmt  : format code (FMT_I..FMT_J, 5-7 illegal)
//   base : instruction supplying all non-immediate bits
//   imm  : immediate (I/S/U) or pc-relative offset (B/J)
//   inst : packed instruction, truncated even when err is set
//   err  : immediate out of range, misaligned or illegal format
module imm_pack
   import imm_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [31:0] base,
   input  logic [31:0] imm,
   output logic [31:0] inst,
   output logic        err
);
   always_comb begin
      inst = fmt == FMT_I ? {imm[11:0], base[19:0]} :
             fmt == FMT_S ? {imm[11:5], base[24:12], imm[4:0], base[6:0]} :
             fmt == FMT_B ? {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]} :
             fmt == FMT_U ? {imm[31:12], base[11:0]} :
             fmt == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]} :
             base;
      err  = (fmt == FMT_I || fmt == FMT_S) ? !in_range(imm, IS_MIN, IS_MAX) :
             fmt == FMT_B ? (!in_range(imm, B_MIN, B_MAX) || imm[0]) :
             fmt == FMT_U ? (|imm[11:0]) :
             fmt == FMT_J ? (!in_range(imm, J_MIN, J_MAX) || imm[0]) :
             1'b1;
   end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready pipeline that packs an immediate into an instruction and flags range errors
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake
//   in_fmt, in_base       : format code and base instruction
//   in_val, in_pc         : immediate (I/S/U) or absolute target (B/J), and instruction address
//   out_valid/out_ready   : result handshake
//   out_inst, out_err     : packed instruction and error flag
//   err_count             : saturating count of delivered errored results (only with IMM_ENC_ERRCNT_EN)
module imm_encoder
   import imm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [31:0] in_base,
   input  logic [31:0] in_val,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_err
`ifdef IMM_ENC_ERRCNT_EN
   ,
   output logic [15:0] err_count
`endif
);
   logic        s1_valid;
   s1_t         s1;
   logic        s1_adv;
   logic [31:0] p_inst;
   logic        p_err;
   assign s1_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s1_adv;
   imm_pack u_pack (
      .fmt  (s1.fmt),
      .base (s1.base),
      .imm  (s1.off),
      .inst (p_inst),
      .err  (p_err)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1       <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid)
            s1 <= '{fmt: in_fmt, base: in_base,
                    off: (in_fmt == FMT_B || in_fmt == FMT_J) ? in_val - in_pc : in_val};
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_inst  <= '0;
         out_err   <= 1'b0;
      end else if (s1_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_inst <= p_inst;
            out_err  <= p_err;
         end
      end
   end
`ifdef IMM_ENC_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= '0;
      else if (out_valid && out_ready && out_err && err_count != 16'hFFFF)
         err_count <= err_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vectors checked against a bench-side encoding model and hand-computed literals
module tb_imm_encoder;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_fmt = '0;
   logic [31:0] in_base = '0;
   logic [31:0] in_val = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_inst;
   logic        out_err;
`ifdef IMM_ENC_ERRCNT_EN
   logic [15:0] err_count;
   int          exp_cnt = 0;
`endif

   typedef struct {
      logic [31:0] inst;
      logic        err;
      logic        has_lit;
      logic [31:0] lit_inst;
      logic        lit_err;
   } exp_t;

   typedef struct {
      logic [2:0]  fmt;
      logic [31:0] base;
      logic [31:0] val;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        err;
   } vec_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   logic        stalled = 1'b0;
   logic [31:0] h_inst;
   logic        h_err;
   logic        saw_block = 1'b0;

   always #5 clk = ~clk;

   imm_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_base   (in_base),
      .in_val    (in_val),
      .in_pc     (in_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_err   (out_err)
`ifdef IMM_ENC_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   // Encoding model: place immediate bits by arithmetic from the format rules.
   function automatic exp_t model(input logic [2:0] f, input logic [31:0] b, input logic [31:0] v,
                                  input logic [31:0] p);
      exp_t        e;
      logic [31:0] o;
      int          s;
      o = (f == 3'd2 || f == 3'd4) ? v - p : v;
      s = o;
      e.has_lit = 1'b0;
      e.lit_inst = '0;
      e.lit_err = 1'b0;
      case (f)
         3'd0: begin
            e.inst = (b & 32'h000FFFFF) | ((o & 32'hFFF) << 20);
            e.err  = s < -2048 || s > 2047;
         end
         3'd1: begin
            e.inst = (b & 32'h01FFF07F) | (((o >> 5) & 32'h7F) << 25) | ((o & 32'h1F) << 7);
            e.err  = s < -2048 || s > 2047;
         end
         3'd2: begin
            e.inst = (b & 32'h01FFF07F) | (((o >> 12) & 32'h1) << 31) | (((o >> 5) & 32'h3F) << 25)
                   | (((o >> 1) & 32'hF) << 8) | (((o >> 11) & 32'h1) << 7);
            e.err  = s < -4096 || s > 4094 || o[0];
         end
         3'd3: begin
            e.inst = (b & 32'h00000FFF) | (o & 32'hFFFFF000);
            e.err  = (o & 32'hFFF) != 0;
         end
         3'd4: begin
            e.inst = (b & 32'h00000FFF) | (((o >> 20) & 32'h1) << 31) | (((o >> 1) & 32'h3FF) << 21)
                   | (((o >> 11) & 32'h1) << 20) | (((o >> 12) & 32'hFF) << 12);
            e.err  = s < -1048576 || s > 1048574 || o[0];
         end
         default: begin
            e.inst = b;
            e.err  = 1'b1;
         end
      endcase
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic send(input logic [2:0] f, input logic [31:0] b, input logic [31:0] v, input logic [31:0] p,
                       input logic hl, input logic [31:0] li, input logic le);
      exp_t e;
      int   t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_fmt = f;
      in_base = b;
      in_val = v;
      in_pc = p;
      #1;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("accept", {31'd0, in_ready}, 32'd1);
      e = model(f, b, v, p);
      e.has_lit = hl;
      e.lit_inst = li;
      e.lit_err = le;
      if (in_ready) q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Scoreboard: checks every delivered result, output stability under back-pressure and err_count.
   initial begin : cmp
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            stalled = 1'b0;
         end else begin
            if (in_valid && !in_ready) saw_block = 1'b1;
`ifdef IMM_ENC_ERRCNT_EN
            chk("err_count", {16'd0, err_count}, exp_cnt);
`endif
            if (out_valid) begin
               if (stalled) begin
                  chk("hold_inst", out_inst, h_inst);
                  chk("hold_err", {31'd0, out_err}, {31'd0, h_err});
               end
               if (out_ready) begin
                  if (q.size() == 0) begin
                     chk("unexpected_result", {31'd0, out_valid}, 32'd0);
                  end else begin
                     e = q.pop_front();
                     chk("inst", out_inst, e.inst);
                     chk("err", {31'd0, out_err}, {31'd0, e.err});
                     if (e.has_lit) begin
                        chk("lit_inst", out_inst, e.lit_inst);
                        chk("lit_err", {31'd0, out_err}, {31'd0, e.lit_err});
                     end
`ifdef IMM_ENC_ERRCNT_EN
                     if (e.err && exp_cnt < 65535) exp_cnt++;
`endif
                  end
               end
               stalled = !out_ready;
               h_inst = out_inst;
               h_err = out_err;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   vec_t vecs[13] = '{
      '{3'd1, 32'h00000023, 32'd8,         32'h0,   32'h00000423, 1'b0},
      '{3'd0, 32'h00000013, 32'd2047,      32'h0,   32'h7FF00013, 1'b0},
      '{3'd0, 32'h00000013, -32'sd2048,    32'h0,   32'h80000013, 1'b0},
      '{3'd0, 32'h00000013, 32'd2048,      32'h0,   32'h80000013, 1'b1},
      '{3'd2, 32'h00000063, 32'h000000F0,  32'h100, 32'hFE0008E3, 1'b0},
      '{3'd2, 32'h00000063, 32'd4094,      32'h0,   32'h7E000FE3, 1'b0},
      '{3'd2, 32'h00000063, 32'd4096,      32'h0,   32'h80000063, 1'b1},
      '{3'd4, 32'h0000006F, 32'h00100000,  32'h0,   32'h8000006F, 1'b1},
      '{3'd4, 32'h0000006F, 32'h00000801,  32'h0,   32'h0010006F, 1'b1},
      '{3'd4, 32'h0000006F, 32'd1048574,   32'h0,   32'h7FFFF06F, 1'b0},
      '{3'd3, 32'h00000037, 32'h12345000,  32'h0,   32'h12345037, 1'b0},
      '{3'd3, 32'h00000037, 32'h12345001,  32'h0,   32'h12345037, 1'b1},
      '{3'd5, 32'hDEADBEEF, 32'h00000000,  32'h0,   32'hDEADBEEF, 1'b1}
   };

   initial begin : main
      exp_t m;
      // Pin the model against hand-computed encodings.
      m = model(3'd0, 32'h13, 32'hFFFFFFFF, 32'h0);
      chk("model_i", m.inst, 32'hFFF00013);
      m = model(3'd2, 32'h63, 32'h0F0, 32'h100);
      chk("model_b", m.inst, 32'hFE0008E3);
      m = model(3'd4, 32'h6F, 32'h801, 32'h0);
      chk("model_j_err", {31'd0, m.err}, 32'd1);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_err", {31'd0, out_err}, 32'd0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("in_ready_after_release", {31'd0, in_ready}, 32'd1);

      // Two-cycle latency with a single I request.
      send(3'd0, 32'h00000013, 32'hFFFFFFFF, 32'h0, 1'b1, 32'hFFF00013, 1'b0);
      idle();
      #1 chk("latency_1cyc_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      #1 chk("latency_2cyc_valid", {31'd0, out_valid}, 32'd1);
      chk("latency_2cyc_inst", out_inst, 32'hFFF00013);
      repeat (2) @(negedge clk);

      // Directed table at full throughput.
      foreach (vecs[i])
         send(vecs[i].fmt, vecs[i].base, vecs[i].val, vecs[i].pc, 1'b1, vecs[i].inst, vecs[i].err);
      idle();
      repeat (4) @(negedge clk);

      // Back-to-back stream with out_ready low for 3 cycles mid-stream.
      fork
         begin
            for (int k = 1; k <= 4; k++)
               send(3'd0, 32'h00000013, k, 32'h0, 1'b1, {k[11:0], 20'h00013}, 1'b0);
            idle();
         end
         begin
            repeat (2) @(negedge clk);
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      repeat (5) @(negedge clk);
      chk("in_ready_dropped", {31'd0, saw_block}, 32'd1);
      chk("drained", q.size(), 32'd0);

      // Reset with both stages occupied.
      out_ready = 1'b0;
      send(3'd0, 32'h00000013, 32'd5, 32'h0, 1'b0, 32'h0, 1'b0);
      send(3'd0, 32'h00000013, 32'd6, 32'h0, 1'b0, 32'h0, 1'b0);
      idle();
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_out_inst", out_inst, 32'd0);
      chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
      q.delete();
`ifdef IMM_ENC_ERRCNT_EN
      chk("async_rst_err_count", {16'd0, err_count}, 32'd0);
      exp_cnt = 0;
`endif
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1 chk("no_stale_output", {31'd0, out_valid}, 32'd0);
      end

      // Pipeline still works after reset.
      send(3'd3, 32'h00000037, 32'h12345000, 32'h0, 1'b1, 32'h12345037, 1'b0);
      idle();
      repeat (4) @(negedge clk);
      chk("final_drained", q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
